// File: rtl/ksz9021_clkmon_pkg.sv
// Shared types and helpers for the KSZ9021 clock monitor.
package ksz9021_clkmon_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    SETTLE,
    MEASURE,
    RUN,
    FAULT
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             inc);
    if (inc && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  // True when cnt lies within +/-tol of exp.
  function automatic logic within_tol(input logic [CNT_W-1:0] cnt,
                                      input int unsigned      exp,
                                      input int unsigned      tol);
    int unsigned c;
    c = {{(32-CNT_W){1'b0}}, cnt};
    if (c >= exp) return (c - exp) <= tol;
    return (exp - c) <= tol;
  endfunction

endpackage

// File: rtl/clkmon_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module clkmon_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the async input through two flops to settle metastability.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ksz9021_clkmon.sv
// KSZ9021 clock monitor: waits for PLL lock, lets it settle, then counts
// divided-clock toggle edges over fixed refclk windows and releases the
// downstream reset only while the measured frequency is in tolerance.
// Build option: KSZ9021_CLKMON_STICKY_FAULT_EN holds FAULT until rst;
// without it FAULT lasts one window and then returns to WAIT_LOCK.
module ksz9021_clkmon
  import ksz9021_clkmon_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 5000,
  parameter int unsigned EXP_COUNT     = 156,
  parameter int unsigned TOL           = 4,
  parameter int unsigned SETTLE_CYCLES = 1000
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              tick_tgl,
  output logic              rst_out,
  output logic              freq_ok,
  output logic              fault,
  output logic [CNT_W-1:0]  meas_count,
  output logic              meas_valid
);

  localparam int unsigned GATE_W   = (GATE_CYCLES > 1)   ? $clog2(GATE_CYCLES)   : 1;
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic lock_s;
  logic tick_s;
  logic tick_dly_q;
  logic tick_edge;

  state_e state_q, state_d;

  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [GATE_W-1:0]   gate_q,   gate_d;
  logic [CNT_W-1:0]    edge_q,   edge_d;
  logic [CNT_W-1:0]    meas_q,   meas_d;
  logic                valid_q,  valid_d;
  logic                rst_out_q, rst_out_d;
  logic                freq_ok_c, fault_c;

  logic                settle_done;
  logic                win_end;
  logic [CNT_W-1:0]    win_count;
  logic                win_pass;

  clkmon_sync2 u_sync_lock (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  clkmon_sync2 u_sync_tick (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (tick_tgl),
    .q_o   (tick_s)
  );

  // Delayed copy of the synced toggle for edge detection.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) tick_dly_q <= 1'b0;
    else     tick_dly_q <= tick_s;
  end

  assign tick_edge   = tick_s ^ tick_dly_q;
  assign settle_done = (settle_q == SETTLE_W'(SETTLE_CYCLES - 1));
  assign win_end     = (gate_q == GATE_W'(GATE_CYCLES - 1));
  // Window result folds in an edge arriving on the final gate cycle.
  assign win_count   = sat_inc(edge_q, tick_edge);
  assign win_pass    = within_tol(win_count, EXP_COUNT, TOL);

  // State register and registered downstream reset.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      rst_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rst_out_q <= rst_out_d;
    end
  end

  // Next-state logic; a lock drop outranks any window-end decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (lock_s) state_d = SETTLE;
      SETTLE: begin
        if (!lock_s)          state_d = WAIT_LOCK;
        else if (settle_done) state_d = MEASURE;
      end
      MEASURE, RUN: begin
        if (!lock_s)      state_d = WAIT_LOCK;
        else if (win_end) state_d = win_pass ? RUN : FAULT;
      end
      FAULT: begin
`ifdef KSZ9021_CLKMON_STICKY_FAULT_EN
        state_d = FAULT;
`else
        if (!lock_s || win_end) state_d = WAIT_LOCK;
`endif
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Status outputs; rst_out follows RUN membership one cycle late.
  always_comb begin
    rst_out_d = (state_q != RUN);
    freq_ok_c = (state_q == RUN);
    fault_c   = (state_q == FAULT);
  end

  // Settle, gate and edge counters plus the measurement result.
  always_comb begin
    settle_d = '0;
    gate_d   = '0;
    edge_d   = '0;
    meas_d   = meas_q;
    valid_d  = 1'b0;
    case (state_q)
      SETTLE: begin
        if (lock_s && !settle_done) settle_d = settle_q + SETTLE_W'(1);
      end
      MEASURE, RUN: begin
        if (lock_s) begin
          if (win_end) begin
            meas_d  = win_count;
            valid_d = 1'b1;
          end else begin
            gate_d = gate_q + GATE_W'(1);
            edge_d = win_count;
          end
        end
      end
      FAULT: begin
`ifndef KSZ9021_CLKMON_STICKY_FAULT_EN
        if (lock_s && !win_end) gate_d = gate_q + GATE_W'(1);
`endif
      end
      default: ;
    endcase
  end

  // Counter and result registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
      gate_q   <= '0;
      edge_q   <= '0;
      meas_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      settle_q <= settle_d;
      gate_q   <= gate_d;
      edge_q   <= edge_d;
      meas_q   <= meas_d;
      valid_q  <= valid_d;
    end
  end

  assign rst_out    = rst_out_q;
  assign freq_ok    = freq_ok_c;
  assign fault      = fault_c;
  assign meas_count = meas_q;
  assign meas_valid = valid_q;

endmodule

// File: tb/tb_ksz9021_clkmon.sv
// Directed bench for ksz9021_clkmon with a measurement scoreboard.
module tb_ksz9021_clkmon;

  logic        refclk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic        tick_tgl;
  logic        rst_out;
  logic        freq_ok;
  logic        fault;
  logic [15:0] meas_count;
  logic        meas_valid;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cycle   = 0;
  int          vp_cnt  = 0;
  int          last_exp = 0;
  int          exp_q[$];

  ksz9021_clkmon #(
    .GATE_CYCLES   (5000),
    .EXP_COUNT     (156),
    .TOL           (4),
    .SETTLE_CYCLES (1000)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .tick_tgl   (tick_tgl),
    .rst_out    (rst_out),
    .freq_ok    (freq_ok),
    .fault      (fault),
    .meas_count (meas_count),
    .meas_valid (meas_valid)
  );

  always #10 refclk = ~refclk;

  always @(posedge refclk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every meas_valid pulse must match the oldest expected count.
  always @(negedge refclk) begin
    if (!rst && meas_valid) begin
      vp_cnt++;
      check("sb_expected_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_meas_count", 32'(meas_count), 32'(exp_q.pop_front()));
    end
  end

  // Drive n toggles, 20 refclk cycles apart, well inside one window.
  task automatic burst(input int n);
    exp_q.push_back(n);
    last_exp = n;
    for (int i = 0; i < n; i++) begin
      tick_tgl = ~tick_tgl;
      repeat (20) @(negedge refclk);
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge refclk);
      if (meas_valid) seen = 1'b1;
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int unsigned t0;
    int          first;
    int          vp0;

    rst        = 1'b1;
    pll_locked = 1'b0;
    tick_tgl   = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset_rst_out",    32'(rst_out),    32'd1);
    check("reset_freq_ok",    32'(freq_ok),    32'd0);
    check("reset_fault",      32'(fault),      32'd0);
    check("reset_meas_count", 32'(meas_count), 32'd0);
    check("reset_meas_valid", 32'(meas_valid), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge refclk);

    // First window at nominal rate -> RUN.
    pll_locked = 1'b1;
    repeat (1100) @(negedge refclk);
    burst(156);
    wait_valid("w156", 3000);
    check("w156_freq_ok",        32'(freq_ok), 32'd1);
    check("w156_rst_out_same",   32'(rst_out), 32'd1);
    @(negedge refclk);
    check("w156_rst_out_next",   32'(rst_out), 32'd0);

    // Tolerance edges while in RUN.
    repeat (100) @(negedge refclk);
    burst(152);
    wait_valid("w152", 5000);
    check("w152_freq_ok", 32'(freq_ok), 32'd1);
    repeat (100) @(negedge refclk);
    burst(160);
    wait_valid("w160", 5000);
    check("w160_freq_ok", 32'(freq_ok), 32'd1);
    repeat (100) @(negedge refclk);
    burst(161);
    wait_valid("w161", 5000);
    check("w161_fault",        32'(fault),   32'd1);
    check("w161_freq_ok",      32'(freq_ok), 32'd0);
    check("w161_rst_out_same", 32'(rst_out), 32'd0);
    @(negedge refclk);
    check("w161_rst_out_next", 32'(rst_out), 32'd1);
    repeat (4998) @(negedge refclk);
    check("fault_last_cycle",  32'(fault),   32'd1);
    @(negedge refclk);
`ifdef KSZ9021_CLKMON_STICKY_FAULT_EN
    check("fault_sticky_hold", 32'(fault), 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge refclk);
    rst = 1'b0;
`else
    check("fault_one_window",  32'(fault), 32'd0);
`endif

    // Lock glitch in SETTLE restarts the settle count; then a 20 MHz window.
    repeat (300) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    pll_locked = 1'b1;
    t0 = cycle;
    repeat (1100) @(negedge refclk);
    burst(125);
    wait_valid("w125", 4000);
    check("settle_restart_latency", 32'((cycle - t0) >= 6001 && (cycle - t0) <= 6005), 32'd1);
    check("w125_fault",   32'(fault),   32'd1);
    check("w125_freq_ok", 32'(freq_ok), 32'd0);
    check("w125_rst_out", 32'(rst_out), 32'd1);

    // Asynchronous reset while in FAULT.
    repeat (100) @(negedge refclk);
    rst = 1'b1;
    #1;
    check("rst_async_rst_out",    32'(rst_out),    32'd1);
    check("rst_async_freq_ok",    32'(freq_ok),    32'd0);
    check("rst_async_fault",      32'(fault),      32'd0);
    check("rst_async_meas_count", 32'(meas_count), 32'd0);
    check("rst_async_meas_valid", 32'(meas_valid), 32'd0);
    repeat (3) @(negedge refclk);
    rst = 1'b0;

    // Good window after reset; no fault re-entry.
    repeat (1100) @(negedge refclk);
    burst(156);
    wait_valid("w_post_rst", 4000);
    check("post_rst_freq_ok", 32'(freq_ok), 32'd1);
    check("post_rst_fault",   32'(fault),   32'd0);
    @(negedge refclk);
    check("post_rst_rst_out", 32'(rst_out), 32'd0);

    // Lock drop in RUN aborts the window.
    repeat (200) @(negedge refclk);
    pll_locked = 1'b0;
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge refclk);
      if (rst_out && first == 0) first = k;
    end
    check("lock_drop_rst_out_4cyc", 32'(first != 0), 32'd1);
    check("lock_drop_freq_ok",      32'(freq_ok),    32'd0);
    vp0 = vp_cnt;
    repeat (5200) @(negedge refclk);
    check("abort_no_valid",  32'(vp_cnt - vp0), 32'd0);
    check("abort_meas_hold", 32'(meas_count),   32'(last_exp));
    check("sb_drained",      32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
